// File: rtl/reg_cmd_parser.sv
// Parses register-access frames (0x57 addr data.. / 0x52 addr) from the RX byte FIFO,
// issues one bus request per frame and holds one response word until rsp_ready.
module reg_cmd_parser #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        fifo_rd_data,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   output logic              reg_req,
   output logic              reg_we,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   input  logic              reg_ack,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              rsp_valid,
   output logic              rsp_we,
   output logic [DATA_W-1:0] rsp_data,
   input  logic              rsp_ready,
   output logic              err_pulse,
   output logic [1:0]        err_code,
   output logic              busy
);
   localparam int NB  = DATA_W / 8;
   localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
   localparam int CW  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam bit TO_EN = (TIMEOUT_CYC > 0);
   localparam logic [CW-1:0]  CNT_MAX   = CW'(TIMEOUT_CYC);
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(NB - 1);
   localparam logic [7:0] OP_WR = 8'h57;
   localparam logic [7:0] OP_RD = 8'h52;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_REQ  = 3'd3;
   localparam logic [2:0] S_RSP  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_we_q, rsp_we_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              err_pulse_q, err_pulse_d;
   logic [1:0]        err_code_q, err_code_d;
   logic              pop;
   logic              cnt_sat;
   logic [CW-1:0]     cnt_inc;

   // Pops are gated by rst so no byte is lost while the parser is held in reset.
   assign pop = !rst && !fifo_empty &&
                (state_q == S_IDLE || state_q == S_ADDR || state_q == S_DATA);
   assign cnt_sat = (cnt_q == CNT_MAX);
   assign cnt_inc = cnt_sat ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      byte_cnt_d  = byte_cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_we_d    = rsp_we_q;
      rsp_data_d  = rsp_data_q;
      err_pulse_d = 1'b0;
      err_code_d  = err_code_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (pop) begin
               if (fifo_rd_data == OP_WR || fifo_rd_data == OP_RD) begin
                  we_d    = (fifo_rd_data == OP_WR);
                  state_d = S_ADDR;
               end else begin
                  err_pulse_d = 1'b1;
                  err_code_d  = 2'd1;
               end
            end
         end
         S_ADDR: begin
            if (pop) begin
               addr_d     = ADDR_W'(fifo_rd_data);
               cnt_d      = '0;
               byte_cnt_d = '0;
               state_d    = we_q ? S_DATA : S_REQ;
            end else if (TO_EN && cnt_sat) begin
               err_pulse_d = 1'b1;
               err_code_d  = 2'd2;
               cnt_d       = '0;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_DATA: begin
            if (pop) begin
               // MSB-first: each new byte enters at the bottom and older bytes move up.
               wdata_d = DATA_W'({wdata_q, fifo_rd_data});
               cnt_d   = '0;
               if (byte_cnt_q == LAST_BYTE) begin
                  state_d = S_REQ;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end else if (TO_EN && cnt_sat) begin
               err_pulse_d = 1'b1;
               err_code_d  = 2'd2;
               cnt_d       = '0;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_REQ: begin
            if (reg_ack) begin
               rsp_valid_d = 1'b1;
               rsp_we_d    = we_q;
               rsp_data_d  = we_q ? '0 : reg_rdata;
               cnt_d       = '0;
               state_d     = S_RSP;
            end else if (TO_EN && cnt_sat) begin
               err_pulse_d = 1'b1;
               err_code_d  = 2'd3;
               cnt_d       = '0;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_RSP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         byte_cnt_q  <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_data_q  <= '0;
         err_pulse_q <= 1'b0;
         err_code_q  <= 2'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_we_q    <= rsp_we_d;
         rsp_data_q  <= rsp_data_d;
         err_pulse_q <= err_pulse_d;
         err_code_q  <= err_code_d;
      end
   end

   assign fifo_rd_en = pop;
   assign reg_req    = (state_q == S_REQ);
   assign reg_we     = we_q;
   assign reg_addr   = addr_q;
   assign reg_wdata  = wdata_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_we     = rsp_we_q;
   assign rsp_data   = rsp_data_q;
   assign err_pulse  = err_pulse_q;
   assign err_code   = err_code_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_reg_cmd_parser.sv
// Bench for reg_cmd_parser: directed frame scenarios followed by random frames
// checked against a frame-level expectation list.
module tb_reg_cmd_parser;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  fifo_rd_data;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic        reg_req, reg_we;
   logic [7:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic        reg_ack;
   logic [31:0] reg_rdata;
   logic        rsp_valid, rsp_we;
   logic [31:0] rsp_data;
   logic        rsp_ready;
   logic        err_pulse;
   logic [1:0]  err_code;
   logic        busy;

   int total = 0;
   int bad   = 0;
   logic [7:0] fq[$];

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [31:0] data;
   } txn_t;
   txn_t exp_q[$];

   reg_cmd_parser #(.ADDR_W(8), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst),
      .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_ack(reg_ack), .reg_rdata(reg_rdata),
      .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
      .err_pulse(err_pulse), .err_code(err_code), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_fifo();
      fifo_empty   = (fq.size() == 0);
      fifo_rd_data = fifo_empty ? 8'h00 : fq[0];
   endtask

   task automatic push(input logic [7:0] b);
      fq.push_back(b);
      drive_fifo();
   endtask

   // Advance one clock; the FIFO model pops when fifo_rd_en was high at the edge.
   task automatic cycle();
      logic popped;
      #1;
      popped = fifo_rd_en;
      @(posedge clk);
      #1;
      if (popped && fq.size() > 0) fq.delete(0);
      drive_fifo();
      reg_ack = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int n;
      n = 0;
      while (!reg_req && n < 40) begin
         cycle();
         n++;
      end
      chk({tag, "_req_seen"}, reg_req, 1'b1);
   endtask

   task automatic handshake(input string tag);
      rsp_ready = 1'b1;
      cycle();
      rsp_ready = 1'b0;
      chk({tag, "_rsp_done"}, {rsp_valid, busy}, 2'b00);
   endtask

   initial begin
      int n_err, last_code, req_seen, rsp_seen;
      int n_bad_exp, n_bad_seen, done, budget, wait_c, dly;
      logic in_req;
      logic [31:0] rsp_exp;
      logic [7:0] b;
      txn_t t;

      rst = 1'b1; reg_ack = 1'b0; reg_rdata = '0; rsp_ready = 1'b0;
      drive_fifo();
      cycle();
      cycle();
      chk("rst_ctrl", {reg_req, reg_we, rsp_valid, rsp_we, err_pulse, err_code, busy, fifo_rd_en}, 0);
      chk("rst_addr", reg_addr, 0);
      chk("rst_wdata", reg_wdata, 0);
      chk("rst_rdata", rsp_data, 0);
      rst = 1'b0;

      // Back-to-back write: request appears on cycle 6, response on cycle 8.
      push(8'h57); push(8'h10); push(8'hDE); push(8'hAD); push(8'hBE); push(8'hEF);
      for (int c = 1; c <= 5; c++) cycle();
      chk("wr_req_c5", reg_req, 1'b0);
      cycle();
      chk("wr_req_c6", {reg_req, reg_we, busy}, 3'b111);
      chk("wr_addr", reg_addr, 8'h10);
      chk("wr_wdata", reg_wdata, 32'hDEADBEEF);
      cycle();
      chk("wr_req_c7", reg_req, 1'b1);
      reg_ack = 1'b1;
      cycle();
      chk("wr_rsp_c8", {rsp_valid, rsp_we, reg_req}, 3'b110);
      chk("wr_rsp_data", rsp_data, 0);
      handshake("wr");

      // Read with ack three cycles after the request rises.
      push(8'h52); push(8'h20);
      cycle();
      cycle();
      chk("rd_req_c2", {reg_req, reg_we}, 2'b10);
      for (int k = 0; k < 3; k++) begin
         chk("rd_addr_hold", {reg_req, reg_addr}, {1'b1, 8'h20});
         cycle();
      end
      chk("rd_addr_ack", {reg_req, reg_addr}, {1'b1, 8'h20});
      reg_ack = 1'b1; reg_rdata = 32'h12345678;
      cycle();
      chk("rd_rsp", {rsp_valid, rsp_we, reg_req}, 3'b100);
      chk("rd_rsp_data", rsp_data, 32'h12345678);
      handshake("rd");

      // Unknown opcode is dropped and the following read still parses.
      push(8'h41); push(8'h52); push(8'h05);
      cycle();
      chk("badop_pulse", {err_pulse, err_code, busy}, {1'b1, 2'd1, 1'b0});
      cycle();
      chk("badop_one_cycle", {err_pulse, busy}, 2'b01);
      cycle();
      chk("badop_rd_req", {reg_req, reg_we, reg_addr}, {2'b10, 8'h05});
      reg_ack = 1'b1; reg_rdata = 32'hCAFEF00D;
      cycle();
      chk("badop_rsp", {rsp_valid, rsp_we, rsp_data}, {2'b10, 32'hCAFEF00D});
      chk("badop_code_hold", err_code, 2'd1);
      handshake("badop");

      // Partial write followed by a long stall.
      push(8'h57); push(8'h10); push(8'hAA);
      cycle(); cycle(); cycle();
      n_err = 0; last_code = 0; req_seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (err_pulse) begin n_err++; last_code = int'(err_code); end
         if (reg_req) req_seen = 1;
         cycle();
      end
      chk("gap_err_count", n_err, 1);
      chk("gap_err_code", last_code, 2);
      chk("gap_no_req", req_seen, 0);
      chk("gap_idle", {busy, err_code}, {1'b0, 2'd2});
      push(8'h57); push(8'h33); push(8'h01); push(8'h02); push(8'h03); push(8'h04);
      wait_req("gap_wr");
      chk("gap_wr_cmd", {reg_we, reg_addr, reg_wdata}, {1'b1, 8'h33, 32'h01020304});
      reg_ack = 1'b1;
      cycle();
      chk("gap_wr_rsp", {rsp_valid, rsp_we, rsp_data}, {2'b11, 32'h0});
      handshake("gap_wr");

      // Response held under backpressure with the next frame already queued.
      push(8'h52); push(8'h40);
      push(8'h57); push(8'h41); push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      wait_req("bp_rd");
      reg_ack = 1'b1; reg_rdata = 32'hA5A55A5A;
      cycle();
      for (int i = 0; i < 10; i++) begin
         chk("bp_hold", {rsp_valid, rsp_we, rsp_data, fifo_rd_en}, {2'b10, 32'hA5A55A5A, 1'b0});
         cycle();
      end
      rsp_ready = 1'b1;
      cycle();
      rsp_ready = 1'b0;
      chk("bp_pop_after_hs", {rsp_valid, fifo_rd_en}, 2'b01);
      wait_req("bp_wr");
      chk("bp_wr_cmd", {reg_we, reg_addr, reg_wdata}, {1'b1, 8'h41, 32'h11223344});
      reg_ack = 1'b1;
      cycle();
      chk("bp_wr_rsp", {rsp_valid, rsp_we}, 2'b11);
      handshake("bp_wr");

      // Bus never acknowledges; a stray ack afterwards must be ignored.
      push(8'h52); push(8'h77);
      wait_req("bto");
      n_err = 0; last_code = 0; rsp_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (err_pulse) begin n_err++; last_code = int'(err_code); end
         if (rsp_valid) rsp_seen = 1;
         cycle();
      end
      chk("bto_err_count", n_err, 1);
      chk("bto_err_code", last_code, 3);
      chk("bto_state", {reg_req, busy, rsp_seen[0]}, 3'b000);
      reg_ack = 1'b1; reg_rdata = 32'hFFFFFFFF;
      cycle();
      cycle();
      chk("stray_ack", {rsp_valid, busy, reg_req}, 3'b000);

      // Reset in the middle of a write frame.
      push(8'h57); push(8'h10); push(8'hDE);
      cycle(); cycle(); cycle();
      rst = 1'b1;
      push(8'h52); push(8'h30);
      #1;
      chk("mid_rst_ctrl", {reg_req, reg_we, rsp_valid, rsp_we, err_pulse, err_code, busy, fifo_rd_en}, 0);
      chk("mid_rst_data", {reg_addr, reg_wdata, rsp_data}, 0);
      cycle();
      rst = 1'b0;
      cycle();
      cycle();
      chk("post_rst_req", {reg_req, reg_we, reg_addr}, {2'b10, 8'h30});
      reg_ack = 1'b1; reg_rdata = 32'h0BADC0DE;
      cycle();
      chk("post_rst_rsp", {rsp_valid, rsp_we, rsp_data}, {2'b10, 32'h0BADC0DE});
      handshake("post_rst");

      // Random frames with interleaved garbage bytes, random ack delay and ready.
      n_bad_exp = 0; n_bad_seen = 0; done = 0; budget = 0; wait_c = 0; dly = 0;
      in_req = 1'b0; rsp_exp = '0;
      for (int f = 0; f < 25; f++) begin
         if ($urandom_range(0, 3) == 0) begin
            b = 8'($urandom);
            if (b == 8'h52 || b == 8'h57) b = 8'h00;
            push(b);
            n_bad_exp++;
         end
         t.we = 1'($urandom); t.addr = 8'($urandom); t.data = $urandom;
         exp_q.push_back(t);
         push(t.we ? 8'h57 : 8'h52);
         push(t.addr);
         if (t.we) for (int k = 3; k >= 0; k--) push(t.data[8*k +: 8]);
      end
      while (done < 25 && budget < 4000) begin
         if (err_pulse) begin
            n_bad_seen++;
            chk("rnd_err_code", err_code, 2'd1);
         end
         if (reg_req) begin
            if (!in_req) begin
               in_req = 1'b1; wait_c = 0; dly = $urandom_range(0, 3);
               chk("rnd_req_cmd", {reg_we, reg_addr}, {exp_q[0].we, exp_q[0].addr});
               if (exp_q[0].we) chk("rnd_req_wdata", reg_wdata, exp_q[0].data);
            end
            if (wait_c == dly) begin
               reg_rdata = $urandom;
               reg_ack   = 1'b1;
               rsp_exp   = exp_q[0].we ? 32'h0 : reg_rdata;
            end
            wait_c++;
         end else begin
            in_req = 1'b0;
         end
         rsp_ready = 1'($urandom);
         if (rsp_valid && rsp_ready) begin
            chk("rnd_rsp", {rsp_we, rsp_data}, {exp_q[0].we, rsp_exp});
            exp_q.delete(0);
            done++;
         end
         cycle();
         budget++;
      end
      rsp_ready = 1'b0;
      chk("rnd_done", done, 25);
      chk("rnd_bad_ops", n_bad_seen, n_bad_exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/reg_cmd_parser.md
# reg_cmd_parser

Consumes bytes from the receive-side byte FIFO and assembles them into register-access command frames. It issues each decoded command on a single-outstanding register bus request/acknowledge handshake, then presents one response word to the downstream response serializer. It sits between the RX byte FIFO and the register file / bus bridge in the UART register access path.

## Interface

Parameters:
- ADDR_W, 8: register address width; exactly one address byte per frame.
- DATA_W, 32: data width; must be a multiple of 8. NB = DATA_W/8 data bytes per write frame.
- TIMEOUT_CYC, 100000: limit for inter-byte gap and bus acknowledge wait, in clk cycles. 0 disables both timeouts.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- fifo_rd_data  in  8  FIFO head byte, show-ahead, valid whenever !fifo_empty.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pop strobe, combinational; head is consumed at this clk edge.
- reg_req  out  1  bus request.
- reg_we  out  1  1 = write, 0 = read.
- reg_addr  out  ADDR_W  bus address.
- reg_wdata  out  DATA_W  write data.
- reg_ack  in  1  bus acknowledge, single-cycle pulse.
- reg_rdata  in  DATA_W  read data, valid with reg_ack.
- rsp_valid  out  1  response available.
- rsp_we  out  1  response belongs to a write (1) or a read (0).
- rsp_data  out  DATA_W  read data; 0 for writes.
- rsp_ready  in  1  downstream accepts response.
- err_pulse  out  1  one-cycle error strobe.
- err_code  out  2  1 = bad opcode, 2 = inter-byte timeout, 3 = bus timeout; holds its last value.
- busy  out  1  high when the state is not IDLE.

## Operation

- Frame format:
  - Write: opcode 0x57, address, then NB data bytes MSB first.
  - Read: opcode 0x52, address.
- States and transitions:
  - IDLE: wait for opcode.
  - ADDR: capture address byte.
  - DATA: capture data bytes, byte counter 0..NB-1.
  - REQ: drive bus request.
  - RSP: present response.
  - IDLE -> ADDR on a valid opcode.
  - ADDR -> DATA for a write, ADDR -> REQ for a read.
  - DATA -> REQ after byte NB-1.
  - REQ -> RSP on reg_ack.
  - RSP -> IDLE when rsp_valid && rsp_ready.
- fifo_rd_en = !fifo_empty && state in {IDLE, ADDR, DATA}. No pops in REQ or RSP; bytes stay buffered.
- The byte is captured on the same edge it is popped. Data shifts in as wdata <= {wdata[DATA_W-9:0], byte}.
- Unknown opcode in IDLE:
  - Byte is dropped.
  - err_pulse fires with err_code=1.
  - State stays IDLE, so resynchronization happens on the next valid opcode.
- Inter-byte timeout:
  - In ADDR/DATA, the gap counter resets on each pop and increments otherwise.
  - When the counter reaches TIMEOUT_CYC: err_code=2, partial frame discarded, go to IDLE.
- Bus timeout:
  - In REQ, a wait counter reaches TIMEOUT_CYC without reg_ack.
  - Result: err_code=3, reg_req dropped, no response, go to IDLE.
- Response content:
  - Write: rsp_we=1, rsp_data=0.
  - Read: rsp_we=0, rsp_data = reg_rdata captured on the reg_ack cycle.
- Timeout counters saturate and are sized $clog2(TIMEOUT_CYC+1).

## Timing

- Reset values: all outputs 0; state IDLE; counters, reg_addr, reg_wdata and rsp_data all 0.
- Reset mid-frame or mid-transaction aborts immediately. No response or error is generated for the aborted frame.
- reg_req rises on the cycle after the edge that popped the final frame byte.
  - With back-to-back bytes, the opcode is popped on cycle 0 and req is high on cycle 2+NB for a write, cycle 2 for a read.
- reg_we, reg_addr and reg_wdata are stable for the whole time reg_req is high.
- reg_ack is legal in the first reg_req cycle. reg_req is low on the cycle after ack.
- Any reg_ack while reg_req is low is ignored.
- rsp_valid rises on the cycle after reg_ack. rsp_valid, rsp_we and rsp_data hold until the rsp_ready handshake.
- The first pop of the next frame can occur on the cycle after the rsp handshake.
- err_pulse is high for exactly one cycle per error event.

## Test plan

- Write frame, bytes 57 10 DE AD BE EF back-to-back:
  - reg_req=1, reg_we=1, reg_addr=0x10, reg_wdata=0xDEADBEEF on cycle 6.
  - ack on cycle 7 -> rsp_valid with rsp_we=1, rsp_data=0 on cycle 8.
- Read frame, bytes 52 20; ack 3 cycles after req with reg_rdata=0x12345678:
  - rsp_we=0, rsp_data=0x12345678.
  - reg_addr stays 0x20 throughout the request.
- Byte 0x41 followed by the read frame 52 05:
  - One err_pulse with err_code=1.
  - The read to 0x05 then completes normally.
- TIMEOUT_CYC=16; bytes 57 10 AA, then a 20-cycle stall:
  - err_code=2 pulse, no reg_req.
  - A subsequent full write frame completes correctly.
- rsp_ready held low 10 cycles with bytes pending in the FIFO:
  - rsp_valid and rsp_data remain stable.
  - fifo_rd_en stays 0 until the handshake.
- rst pulsed after 57 10 DE:
  - All outputs 0 and busy=0.
  - The next frame 52 30 is parsed from its opcode and reads 0x30.
